// File: rtl/fetch_sequencer.sv
// Run controller for the single-cycle core: launches and halts programs, stalls fetch
// during multi-cycle data-memory accesses and keeps per-run cycle/instruction counters.
//
// state  | meaning
// IDLE   | out of reset, PC held at 0, waiting for a start rise
// LAUNCH | one cycle: PC still held at 0, counters cleared
// RUN    | executing, one instruction per cycle unless a load/store stalls
// MWAIT  | load/store in flight, fetch held until the wait counter reaches 1
// HALT   | program finished, counters frozen, waiting for a fresh start rise
module fetch_sequencer #(
    parameter int MEM_WAIT = 2,
    parameter int CYC_W    = 16
) (
    input  logic             CLK,
    input  logic             Init,
    input  logic             start,
    input  logic             halt,
    input  logic             mem_op,
    input  logic [1:0]       exp_flag,
    output logic             pc_rst,
    output logic             Stall,
    output logic             done,
    output logic [1:0]       exp_error,
    output logic             busy,
    output logic [CYC_W-1:0] cycle_count,
    output logic [CYC_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_MWAIT  = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0]       WAIT_LOAD = 4'(MEM_WAIT);
    localparam logic             MEM_EN    = (MEM_WAIT > 0);
    localparam logic [CYC_W-1:0] CNT_MAX   = '1;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;
    logic       start_q;
    logic       start_rise;
    logic       exc_valid;
    logic       cyc_inc;
    logic       instr_inc;

    assign start_rise = start & ~start_q;
    // Class 11 is reserved and must not redirect fetch.
    assign exc_valid  = (exp_flag == 2'b01) || (exp_flag == 2'b10);

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        Stall     = 1'b0;
        exp_error = 2'b00;
        case (state)
            S_IDLE: begin
                if (start_rise) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (halt) begin
                    state_nxt = S_HALT;
                end else if (exc_valid) begin
                    exp_error = exp_flag;
                end else if (mem_op && MEM_EN) begin
                    Stall     = 1'b1;
                    wait_nxt  = WAIT_LOAD;
                    state_nxt = S_MWAIT;
                end
            end
            S_MWAIT: begin
                Stall    = (wait_cnt > 4'd1);
                wait_nxt = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    wait_nxt  = 4'd0;
                    state_nxt = S_RUN;
                end
            end
            S_HALT: begin
                if (start_rise) state_nxt = S_LAUNCH;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign pc_rst    = (state == S_IDLE) || (state == S_LAUNCH);
    assign done      = (state == S_HALT);
    assign busy      = (state == S_LAUNCH) || (state == S_RUN) || (state == S_MWAIT);
    assign cyc_inc   = (state == S_RUN) || (state == S_MWAIT);
    assign instr_inc = ((state == S_RUN) && !Stall) || ((state == S_MWAIT) && (wait_cnt == 4'd1));

    always_ff @(posedge CLK or posedge Init) begin
        if (Init) begin
            state    <= S_IDLE;
            start_q  <= 1'b0;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            start_q  <= start;
            wait_cnt <= wait_nxt;
        end
    end

    // Counters saturate rather than wrap so a long run never reads as a short one.
    always_ff @(posedge CLK or posedge Init) begin
        if (Init) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else if (state == S_LAUNCH) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (cyc_inc && (cycle_count != CNT_MAX)) cycle_count <= cycle_count + 1'b1;
            if (instr_inc && (instr_count != CNT_MAX)) instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Top-level run controller for the single-cycle CPU core. It sequences program launch and halt, generates the `Stall`, `done`, `exp_error` and PC-reset controls consumed by the instruction-fetch stage, and inserts wait cycles for multi-cycle data-memory accesses. It sits between the testbench start/done handshake, the decoder/ALU status lines and the fetch stage, and it keeps per-run cycle and instruction counters.

## Interface
- `MEM_WAIT`, default 2: stall cycles per load/store; legal range 0..15.
- `CYC_W`, default 16: width of both counters.

- `CLK`  in  1  system clock, rising edge.
- `Init`  in  1  reset, asynchronous, active-high.
- `start`  in  1  run request from the testbench; a rising edge launches a program.
- `halt`  in  1  decoder: current instruction is halt.
- `mem_op`  in  1  decoder: current instruction is a load or store.
- `exp_flag`  in  2  ALU exception class: 00 none, 01 positive overflow, 10 negative overflow, 11 reserved and treated as none.
- `pc_rst`  out  1  drives the fetch stage `Init`, which holds PC at 0.
- `Stall`  out  1  fetch stage holds PC.
- `done`  out  1  program halted; fetch stage freezes.
- `exp_error`  out  2  exception redirect request to the fetch stage.
- `busy`  out  1  program in progress.
- `cycle_count`  out  CYC_W  cycles spent in RUN/MWAIT this run; saturating.
- `instr_count`  out  CYC_W  instructions retired this run; saturating.

## Operation
- States are IDLE, LAUNCH, RUN, MWAIT and HALT.
- Start edge detection:
  - `start_q` is a register that resets to 0; `start_rise = start & ~start_q`.
  - A `start` already high when reset is released counts as a rise at the first clock.
- IDLE:
  - Outputs: `pc_rst`=1, all other outputs 0.
  - On `start_rise`, go to LAUNCH.
- LAUNCH (exactly one cycle):
  - Outputs: `pc_rst`=1, `busy`=1.
  - Clears both counters, then goes to RUN.
- RUN (`busy`=1). Priority is halt, then exception, then memory, then normal:
  - `halt`: `Stall`=0, `exp_error`=00. Go to HALT. The halt instruction counts as retired.
  - `exp_flag` is 01 or 10: `exp_error`=`exp_flag` (combinational, same cycle), `Stall`=0. Stay in RUN; the fetch stage redirects at the next edge.
  - `mem_op` with `MEM_WAIT`>0: `Stall`=1. Load the wait counter with `MEM_WAIT` and go to MWAIT.
  - Otherwise: `Stall`=0 and stay in RUN.
  - With `MEM_WAIT`=0, `mem_op` is ignored.
- MWAIT (`busy`=1):
  - `halt`, `mem_op` and `exp_flag` are ignored; `exp_error`=00.
  - `Stall`=1 while the wait counter is >1. The counter decrements each cycle.
  - When the counter is 1: `Stall`=0, go to RUN, and the instruction retires.
  - A load/store therefore occupies `MEM_WAIT`+1 cycles and holds `Stall` high for `MEM_WAIT` of them.
- HALT:
  - Outputs: `done`=1, `pc_rst`=0, `Stall`=0, `exp_error`=00, `busy`=0.
  - Counters hold.
  - On `start_rise`, go to LAUNCH. A new run requires `start` to drop and rise again.
- Output decode:
  - `pc_rst`, `done` and `busy` are decoded from the state only.
  - `Stall` and `exp_error` are functions of the state and the RUN-cycle inputs.
  - `exp_error` is forced to 00 outside RUN.
- `cycle_count` increments on every clock spent in RUN or MWAIT.
- `instr_count` increments on `(RUN & ~Stall) | (MWAIT & wait counter==1)`.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset values (asynchronous, with `Init`=1): state=IDLE, `start_q`=0, wait counter=0, both counters=0.
- Output values under reset: `pc_rst`=1, `Stall`=0, `done`=0, `exp_error`=00, `busy`=0.
- `Init` asserted in any state, including mid-MWAIT or HALT, returns everything to reset values immediately.
- Launch timing:
  - `start_rise` is sampled at edge k; LAUNCH is the state from k to k+1.
  - RUN begins at k+1, with the instruction at PC 0 presented.
- Halt timing: `halt` in RUN at cycle n gives `done`=1 from edge n+1 onward.
- Simultaneous events:
  - `halt` with `mem_op`: halt wins, no stall.
  - `halt` with `exp_flag`≠00: halt wins, `exp_error`=00.
  - `exp_flag`≠00 with `mem_op`: exception wins, no stall.
  - `start` pulses while busy are ignored, but still update `start_q`.

## Test plan
- Reset then launch: `start` held high through reset release gives `pc_rst`=1 for 2 cycles (IDLE, LAUNCH), then RUN with `busy`=1 and `cycle_count` counting from 1.
- Memory wait with `MEM_WAIT`=2: one `mem_op` cycle gives `Stall`=1,1,0 over 3 cycles, and `instr_count` increments exactly once on the third cycle.
- Exception: `exp_flag`=10 in RUN gives `exp_error`=10 in the same cycle with `Stall`=0. `exp_flag`=11 gives `exp_error`=00. A `exp_flag`=01 during MWAIT gives `exp_error`=00.
- Halt and relaunch: 5 plain instructions then `halt` gives `done`=1, `instr_count`=6 and `cycle_count`=6, both holding. A `start` falling then rising edge re-enters LAUNCH and clears the counters.
- Priority and edge cases: `halt`+`mem_op`+`exp_flag`=01 together gives HALT next with `Stall`=0 and `exp_error`=00. With `MEM_WAIT`=0, `mem_op` never raises `Stall`.
- Async reset mid-MWAIT, plus saturation: asserting `Init` between clock edges forces IDLE outputs immediately. With `CYC_W`=4, a run of 20 cycles gives `cycle_count`=15.
